// File: rtl/port_r_pair_buffer_pkg.sv
// Shared packing definitions for read-result pairs.
// The serializer and the pair buffer both use these to agree on the pair layout.
// Pair layout, LSB first: slot1 data, slot1 valid, slot2 data, slot2 valid.
// The all-invalid pair is encoded as all zeros.
package port_r_pair_buffer_pkg;

    // Next-value source for the presented pair on each edge.
    typedef enum logic [1:0] {
        SelHold,    // freeze asserted: keep the presented pair
        SelPop,     // load the FIFO head
        SelBypass,  // FIFO empty: load the compacted incoming pair directly
        SelIdle     // nothing available: present the all-invalid pair
    } pair_sel_e;

    // Every bit of the all-invalid pair takes this value.
    localparam logic PAIR_INVALID_FILL = 1'b0;

    function automatic int unsigned pair_w(input int unsigned width);
        return 2 * (width + 1);
    endfunction

    function automatic int unsigned slot1_data_lo(input int unsigned width);
        return 0 * width;
    endfunction

    function automatic int unsigned slot1_valid_bit(input int unsigned width);
        return width;
    endfunction

    function automatic int unsigned slot2_data_lo(input int unsigned width);
        return width + 1;
    endfunction

    function automatic int unsigned slot2_valid_bit(input int unsigned width);
        return 2 * width + 1;
    endfunction

endpackage

// File: rtl/port_r_pair_fifo.sv
// Synchronous FIFO of DEPTH packed pairs.
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   push, wdata    enqueue one pair (ignored when full unless popping on the same edge)
//   pop, rdata     dequeue the head; rdata shows the head combinationally from storage
//   count          pairs held
//   full, empty    decoded from count
module port_r_pair_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PAIR_W = 18
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [PAIR_W-1:0]          wdata,
    input  logic                       pop,
    output logic [PAIR_W-1:0]          rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PAIR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Push into a full FIFO is legal only when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rdata = mem[rptr_q];
    assign count = count_q;

    // Storage needs no reset; pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q] <= wdata;
        end
    end

    // Pointers are exactly PTR_W bits so they wrap on their own with DEPTH a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_W'(1);
            if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/port_r_pair_buffer.sv
// Registered staging buffer feeding the read-port serializer.
// Compacts each bank pair so a lone valid entry sits in slot 1, queues pairs in a FIFO,
// and presents them on registered entry1/entry2 outputs that advance only when
// freeze_inputs is low.
// Ports:
//   clk, reset_n                   clock and asynchronous active-low reset
//   in1_*, in2_*                   bank read results, one pair per cycle, cannot stall
//   freeze_inputs                  serializer hold request
//   entry1_*, entry2_*             presented pair (registered)
//   in_ready                       FIFO not full (advisory)
//   occupancy                      pairs queued behind the presented pair
//   overflow                       sticky: an incoming pair was dropped
module port_r_pair_buffer
    import port_r_pair_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           in1_data,
    input  logic                       in1_valid,
    input  logic [WIDTH-1:0]           in2_data,
    input  logic                       in2_valid,
    input  logic                       freeze_inputs,
    output logic [WIDTH-1:0]           entry1_data,
    output logic                       entry1_valid,
    output logic [WIDTH-1:0]           entry2_data,
    output logic                       entry2_valid,
    output logic                       in_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       overflow
);
    localparam int unsigned PAIR_W = pair_w(WIDTH);
    localparam int unsigned S1D_LO = slot1_data_lo(WIDTH);
    localparam int unsigned S1V    = slot1_valid_bit(WIDTH);
    localparam int unsigned S2D_LO = slot2_data_lo(WIDTH);
    localparam int unsigned S2V    = slot2_valid_bit(WIDTH);

    localparam logic [PAIR_W-1:0] PAIR_INVALID = {PAIR_W{PAIR_INVALID_FILL}};

    logic [PAIR_W-1:0] in_pair;
    logic              in_any;
    logic [PAIR_W-1:0] head_pair;
    logic              fifo_full, fifo_empty;
    logic              fifo_push;
    logic              drop;
    pair_sel_e         sel;
    logic [PAIR_W-1:0] pres_d, pres_q;
    logic              overflow_q;

    // Compaction: a lone valid entry always lands in slot 1; invalid slots carry zero data.
    always_comb begin
        in_pair = PAIR_INVALID;
        in_any  = in1_valid || in2_valid;
        if (in1_valid) begin
            in_pair[S1D_LO +: WIDTH] = in1_data;
            in_pair[S1V]             = 1'b1;
            if (in2_valid) begin
                in_pair[S2D_LO +: WIDTH] = in2_data;
                in_pair[S2V]             = 1'b1;
            end
        end else if (in2_valid) begin
            in_pair[S1D_LO +: WIDTH] = in2_data;
            in_pair[S1V]             = 1'b1;
        end
    end

    // Each unfrozen edge consumes the presented pair; queued pairs take priority over bypass.
    always_comb begin
        if (freeze_inputs)    sel = SelHold;
        else if (!fifo_empty) sel = SelPop;
        else if (in_any)      sel = SelBypass;
        else                  sel = SelIdle;
    end

    always_comb begin
        pres_d = pres_q;
        unique case (sel)
            SelHold:   pres_d = pres_q;
            SelPop:    pres_d = head_pair;
            SelBypass: pres_d = in_pair;
            SelIdle:   pres_d = PAIR_INVALID;
            default:   pres_d = pres_q;
        endcase
    end

    // Full with a pop on the same edge still accepts the new pair.
    assign fifo_push = in_any && (sel != SelBypass) && (!fifo_full || sel == SelPop);
    assign drop      = in_any && fifo_full && (sel != SelPop);

    port_r_pair_fifo #(
        .DEPTH  (DEPTH),
        .PAIR_W (PAIR_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .wdata   (in_pair),
        .pop     (sel == SelPop),
        .rdata   (head_pair),
        .count   (occupancy),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pres_q     <= PAIR_INVALID;
            overflow_q <= 1'b0;
        end else begin
            pres_q <= pres_d;
            if (drop) overflow_q <= 1'b1;
        end
    end

    assign entry1_data  = pres_q[S1D_LO +: WIDTH];
    assign entry1_valid = pres_q[S1V];
    assign entry2_data  = pres_q[S2D_LO +: WIDTH];
    assign entry2_valid = pres_q[S2V];
    assign in_ready     = !fifo_full;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_port_r_pair_buffer.sv
// Directed self-checking bench for port_r_pair_buffer (WIDTH=8, DEPTH=4).
module tb_port_r_pair_buffer;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [WIDTH-1:0] in1_data = '0, in2_data = '0;
    logic             in1_valid = 1'b0, in2_valid = 1'b0;
    logic             freeze_inputs = 1'b0;
    logic [WIDTH-1:0] entry1_data, entry2_data;
    logic             entry1_valid, entry2_valid;
    logic             in_ready;
    logic [2:0]       occupancy;
    logic             overflow;

    int n_checks = 0;
    int n_pass   = 0;

    // Serializer model state
    logic             ser_hold = 1'b0;
    logic [WIDTH-1:0] ser_lat  = '0;
    logic [WIDTH-1:0] stream[$];

    always #5 clk = ~clk;

    port_r_pair_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in1_data      (in1_data),
        .in1_valid     (in1_valid),
        .in2_data      (in2_data),
        .in2_valid     (in2_valid),
        .freeze_inputs (freeze_inputs),
        .entry1_data   (entry1_data),
        .entry1_valid  (entry1_valid),
        .entry2_data   (entry2_data),
        .entry2_valid  (entry2_valid),
        .in_ready      (in_ready),
        .occupancy     (occupancy),
        .overflow      (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive(input logic v1, input logic [7:0] d1, input logic v2,
                         input logic [7:0] d2, input logic frz);
        in1_valid = v1; in1_data = d1; in2_valid = v2; in2_data = d2; freeze_inputs = frz;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One edge with the serializer model driving freeze_inputs.
    task automatic ser_tick();
        logic             frz, p1v, p2v;
        logic [WIDTH-1:0] p1d, p2d;
        frz = ser_hold;
        freeze_inputs = frz;
        p1v = entry1_valid; p1d = entry1_data;
        p2v = entry2_valid; p2d = entry2_data;
        tick();
        if (!frz) begin
            if (p1v) stream.push_back(p1d);
            if (p2v) begin
                ser_hold = 1'b1;
                ser_lat  = p2d;
            end
        end else begin
            stream.push_back(ser_lat);
            ser_hold = 1'b0;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_e1d"}, 32'(entry1_data), 32'h0);
        check({tag, "_e1v"}, 32'(entry1_valid), 32'h0);
        check({tag, "_e2d"}, 32'(entry2_data), 32'h0);
        check({tag, "_e2v"}, 32'(entry2_valid), 32'h0);
        check({tag, "_occ"}, 32'(occupancy), 32'h0);
        check({tag, "_ovf"}, 32'(overflow), 32'h0);
        check({tag, "_rdy"}, 32'(in_ready), 32'h1);
    endtask

    initial begin
        logic [7:0] exp_stream[5];
        logic [7:0] b;

        // Reset
        #12;
        check_reset_state("rst");
        reset_n = 1'b1;
        #3;

        // Lone in1 bypasses
        drive(1'b1, 8'h11, 1'b0, 8'h00, 1'b0);
        tick();
        check("byp1_e1d", 32'(entry1_data), 32'h11);
        check("byp1_e1v", 32'(entry1_valid), 32'h1);
        check("byp1_e2v", 32'(entry2_valid), 32'h0);
        check("byp1_e2d", 32'(entry2_data), 32'h0);
        check("byp1_occ", 32'(occupancy), 32'h0);

        // Lone in2 compacts into slot 1, not pushed
        drive(1'b0, 8'h00, 1'b1, 8'h22, 1'b0);
        tick();
        check("byp2_e1d", 32'(entry1_data), 32'h22);
        check("byp2_e1v", 32'(entry1_valid), 32'h1);
        check("byp2_e2v", 32'(entry2_valid), 32'h0);
        check("byp2_occ", 32'(occupancy), 32'h0);

        // Idle edge clears the presented pair
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        tick();
        check("idle_e1v", 32'(entry1_valid), 32'h0);

        // Serializer stream: A1 A2 B1 B2 C1
        ser_hold = 1'b0;
        drive(1'b1, 8'hA1, 1'b1, 8'hA2, 1'b0); ser_tick();
        drive(1'b1, 8'hB1, 1'b1, 8'hB2, 1'b0); ser_tick();
        drive(1'b1, 8'hC1, 1'b0, 8'h00, 1'b0); ser_tick();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) ser_tick();
        freeze_inputs = 1'b0;
        exp_stream = '{8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'hC1};
        check("ser_len", 32'(stream.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            b = (i < stream.size()) ? stream[i] : 8'hxx;
            check($sformatf("ser_%0d", i), 32'(b), 32'(exp_stream[i]));
        end

        // Frozen fill to full, then drop the fifth pair
        for (int k = 0; k < 5; k++) begin
            b = 8'h31 + 8'(k * 16);
            drive(1'b1, b, 1'b1, b + 8'h01, 1'b1);
            tick();
            if (k < 3) begin
                check($sformatf("fill_occ%0d", k), 32'(occupancy), 32'(k + 1));
                check($sformatf("fill_rdy%0d", k), 32'(in_ready), 32'h1);
            end else if (k == 3) begin
                check("fill_occ3", 32'(occupancy), 32'd4);
                check("fill_rdy3", 32'(in_ready), 32'h0);
                check("fill_ovf3", 32'(overflow), 32'h0);
            end else begin
                check("drop_occ", 32'(occupancy), 32'd4);
                check("drop_ovf", 32'(overflow), 32'h1);
            end
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        tick();
        check("ovf_sticky", 32'(overflow), 32'h1);
        check("hold_e1v", 32'(entry1_valid), 32'h0);

        // Drain in order
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            b = 8'h31 + 8'(k * 16);
            check($sformatf("drain_e1d%0d", k), 32'(entry1_data), 32'(b));
            check($sformatf("drain_e2d%0d", k), 32'(entry2_data), 32'(b + 8'h01));
            check($sformatf("drain_e2v%0d", k), 32'(entry2_valid), 32'h1);
            check($sformatf("drain_occ%0d", k), 32'(occupancy), 32'(3 - k));
        end
        tick();
        check("drained_e1v", 32'(entry1_valid), 32'h0);
        check("drained_ovf", 32'(overflow), 32'h1);

        // Clean reset, then fill to full frozen
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b = 8'h81 + 8'(k * 16);
            drive(1'b1, b, 1'b1, b + 8'h01, 1'b1);
            tick();
        end
        check("full2_occ", 32'(occupancy), 32'd4);

        // Full with freeze low: pop and push together
        drive(1'b1, 8'hC5, 1'b1, 8'hC6, 1'b0);
        tick();
        check("pp_occ", 32'(occupancy), 32'd4);
        check("pp_ovf", 32'(overflow), 32'h0);
        check("pp_e1d", 32'(entry1_data), 32'h81);
        check("pp_e2d", 32'(entry2_data), 32'h82);
        check("pp_rdy", 32'(in_ready), 32'h0);

        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        tick();
        check("mid_occ", 32'(occupancy), 32'd3);
        check("mid_e1d", 32'(entry1_data), 32'h91);

        // Asynchronous reset mid-drain
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state("arst");
        #1;
        reset_n = 1'b1;

        drive(1'b1, 8'hE1, 1'b1, 8'hE2, 1'b0);
        tick();
        check("post_e1d", 32'(entry1_data), 32'hE1);
        check("post_e2d", 32'(entry2_data), 32'hE2);
        check("post_e2v", 32'(entry2_valid), 32'h1);
        check("post_occ", 32'(occupancy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
